// File: rtl/pkt_merge_avlstrm.sv
// Two-input packet-atomic round-robin merge of Avalon-ST packet streams.
// in0 carries the no-check path and in1 the checked path. Once a packet is
// granted, it owns the output until its eop beat is accepted. Beats without
// sop that arrive while idle are orphans; they are consumed and counted,
// not forwarded.
module pkt_merge_avlstrm #(
  parameter int unsigned DW = 512,
  parameter int unsigned EW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // in0: no-check stream
  input  logic [DW-1:0] i_in0_data,
  input  logic          i_in0_valid,
  output logic          o_in0_ready_c,
  input  logic          i_in0_sop,
  input  logic          i_in0_eop,
  input  logic [EW-1:0] i_in0_empty,
  // in1: checked stream
  input  logic [DW-1:0] i_in1_data,
  input  logic          i_in1_valid,
  output logic          o_in1_ready_c,
  input  logic          i_in1_sop,
  input  logic          i_in1_eop,
  input  logic [EW-1:0] i_in1_empty,
  // merged output stream
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_out_sop,
  output logic          o_out_eop,
  output logic [EW-1:0] o_out_empty,
  // statistics
  output logic [31:0]   o_stats_in0_pkt,
  output logic [31:0]   o_stats_in1_pkt,
  output logic [31:0]   o_stats_out_pkt,
  output logic [31:0]   o_stats_drop_beat
);

  localparam int unsigned SW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_rr;
  logic            w_next_rr;

  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_sop;
  logic            r_out_eop;
  logic [EW-1:0]   r_out_empty;

  logic [SW-1:0]   r_stats_in0_pkt;
  logic [SW-1:0]   r_stats_in1_pkt;
  logic [SW-1:0]   r_stats_out_pkt;
  logic [SW-1:0]   r_stats_drop_beat;

  logic            w_load_en;
  logic            w_cand0;
  logic            w_cand1;
  logic            w_sel;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_fwd;
  logic            w_fwd_eop;
  logic            w_drop;
  logic            w_out_xfer_eop;

  // Output register can take a new beat when empty or draining this cycle.
  assign w_load_en = ~r_out_valid | i_out_ready;
  assign w_cand0   = i_in0_valid & i_in0_sop;
  assign w_cand1   = i_in1_valid & i_in1_sop;

  // State register and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rr    <= w_next_rr;
    end
  end

  // Arbitration, ready generation and next-state decode.
  always_comb begin
    w_next_state = r_state;
    w_next_rr    = r_rr;
    w_sel        = 1'b0;
    w_rdy0       = 1'b0;
    w_rdy1       = 1'b0;
    w_fwd        = 1'b0;
    w_fwd_eop    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cand0 | w_cand1) begin
          w_sel = (w_cand0 & w_cand1) ? r_rr : w_cand1;
          if (w_sel) begin
            w_rdy1 = w_load_en;
          end else begin
            w_rdy0 = w_load_en;
          end
          if (w_load_en) begin
            w_fwd     = 1'b1;
            w_fwd_eop = w_sel ? i_in1_eop : i_in0_eop;
            w_next_rr = ~w_sel;
            if (!w_fwd_eop) begin
              w_next_state = w_sel ? ST_LOCK1 : ST_LOCK0;
            end
          end
        end else if (i_in0_valid) begin
          // in0 orphan wins over an in1 orphan
          w_rdy0 = w_load_en;
          w_drop = w_load_en;
        end else if (i_in1_valid) begin
          w_rdy1 = w_load_en;
          w_drop = w_load_en;
        end
      end
      ST_LOCK0: begin
        w_sel  = 1'b0;
        w_rdy0 = w_load_en;
        if (w_load_en & i_in0_valid) begin
          w_fwd     = 1'b1;
          w_fwd_eop = i_in0_eop;
          if (i_in0_eop) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_LOCK1: begin
        w_sel  = 1'b1;
        w_rdy1 = w_load_en;
        if (w_load_en & i_in1_valid) begin
          w_fwd     = 1'b1;
          w_fwd_eop = i_in1_eop;
          if (i_in1_eop) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Inputs see no ready while reset is held.
  assign o_in0_ready_c = w_rdy0 & ~i_rst;
  assign o_in1_ready_c = w_rdy1 & ~i_rst;

  // Single output register stage; fields hold while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_fwd;
      if (w_fwd) begin
        if (w_sel) begin
          r_out_data  <= i_in1_data;
          r_out_sop   <= i_in1_sop;
          r_out_eop   <= i_in1_eop;
          r_out_empty <= i_in1_empty;
        end else begin
          r_out_data  <= i_in0_data;
          r_out_sop   <= i_in0_sop;
          r_out_eop   <= i_in0_eop;
          r_out_empty <= i_in0_empty;
        end
      end
    end
  end

  assign w_out_xfer_eop = r_out_valid & i_out_ready & r_out_eop;

  // Free-running packet and drop counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stats_in0_pkt   <= '0;
      r_stats_in1_pkt   <= '0;
      r_stats_out_pkt   <= '0;
      r_stats_drop_beat <= '0;
    end else begin
      if (w_fwd & w_fwd_eop & ~w_sel) begin
        r_stats_in0_pkt <= r_stats_in0_pkt + SW'(1);
      end
      if (w_fwd & w_fwd_eop & w_sel) begin
        r_stats_in1_pkt <= r_stats_in1_pkt + SW'(1);
      end
      if (w_out_xfer_eop) begin
        r_stats_out_pkt <= r_stats_out_pkt + SW'(1);
      end
      if (w_drop) begin
        r_stats_drop_beat <= r_stats_drop_beat + SW'(1);
      end
    end
  end

  assign o_out_data        = r_out_data;
  assign o_out_valid       = r_out_valid;
  assign o_out_sop         = r_out_sop;
  assign o_out_eop         = r_out_eop;
  assign o_out_empty       = r_out_empty;
  assign o_stats_in0_pkt   = r_stats_in0_pkt;
  assign o_stats_in1_pkt   = r_stats_in1_pkt;
  assign o_stats_out_pkt   = r_stats_out_pkt;
  assign o_stats_drop_beat = r_stats_drop_beat;

endmodule

// File: doc/pkt_merge_avlstrm.md
Name: pkt_merge_avlstrm

Overview:
- Two-input, packet-atomic round-robin merge of Avalon-ST packet streams into one output stream.
- It is the join counterpart of the packet fork: it recombines the no-check path (in0) and the checked path (in1) into a single egress stream toward the output FIFO.
- It never interleaves beats of different packets.
- It exports 32-bit statistics counters.

Parameters:
DW, 512, data width in bits of all three streams
EW, 6, width of the empty field (log2(DW/8))

Ports:
Clk  input  1  clock
Rst  input  1  asynchronous reset, active-high
in0  avl_stream_if.rx  DW  no-check packet stream: data, valid, ready, sop, eop, empty
in1  avl_stream_if.rx  DW  checked packet stream, same fields
out  avl_stream_if.tx  DW  merged packet stream, same fields
stats_in0_pkt  output  32  count of packets accepted from in0 (eop beats)
stats_in1_pkt  output  32  count of packets accepted from in1
stats_out_pkt  output  32  count of packets sent on out (eop beats)
stats_drop_beat  output  32  count of orphan beats discarded

Behaviour:
- Handshake on all streams: valid/ready, ready latency 0. A beat transfers when valid&ready are both high in the same cycle.
- Output stage is one register; latency from an accepted input beat to out.valid is 1 cycle.
- load_en = ~out.valid | out.ready. Full throughput is one beat per cycle with no bubbles between packets.
- Reset (Rst=1, takes effect asynchronously):
  - out.valid=0; out data, sop, eop and empty = 0.
  - State=IDLE; rr=0, so in0 has priority first.
  - All stats counters = 0.
  - in0.ready = in1.ready = 0 while Rst is high.
- State machine has states IDLE, LOCK0, LOCK1.
- IDLE:
  - An input is a candidate if valid&sop.
  - If both are candidates, grant the input given by rr. If only one is a candidate, grant it.
  - The granted input's ready = load_en; the other input's ready = 0.
  - When the granted sop beat is accepted:
    - rr = ~granted index.
    - If that beat also has eop, stay IDLE (single-beat packet). Otherwise go to LOCK0 or LOCK1.
  - An input with valid=1, sop=0 in IDLE is an orphan beat:
    - It is accepted (ready=1) only if no candidate exists in that cycle; in0 orphans take precedence over in1 orphans.
    - It is discarded, not forwarded, and increments stats_drop_beat.
- LOCKn:
  - in_n.ready = load_en; the other input's ready = 0.
  - Beats pass through unchanged, including data, empty, and any stray sop.
  - Accepting a beat with eop returns to IDLE in the same cycle. Arbitration resumes on the next cycle.
- Output register:
  - On load_en with an accepted forwarded beat, load the beat's fields and set valid=1.
  - On load_en with no accepted forwarded beat, set valid=0.
  - Output fields hold stable while out.valid=1 and out.ready=0.
- Stats:
  - stats_in0_pkt and stats_in1_pkt increment on an accepted forwarded eop beat of that input.
  - stats_out_pkt increments on an out eop transfer.
  - All counters are 32-bit free-running and wrap from 0xFFFFFFFF to 0.
  - At most +1 per counter per cycle.
- Boundary conditions:
  - Simultaneous sop on both inputs: the rr winner goes first; the loser keeps valid and is granted at the next IDLE.
  - A stalled output (out.ready=0 with out.valid=1) freezes the state machine: no input is accepted.
  - A reset mid-packet discards the partial packet and returns to IDLE. The upstream side must also be reset.

Test Plan:
- Single 3-beat packet on in0, in1 idle, out.ready=1 → out shows sop,-,eop on cycles 1..3 after acceptance; stats_in0_pkt=1, stats_out_pkt=1.
- Both inputs present a 2-beat packet at cycle 0 after reset → out order is in0 beats then in1 beats, back-to-back with no idle cycle; then 4 more simultaneous pairs alternate in1,in0,in1,in0.
- in1 mid-packet (LOCK1) while in0 asserts sop → in0.ready stays 0 until in1 eop accepted; no interleaving on out.
- out.ready toggled 1,0,0,1 during a 4-beat packet → out fields stable while stalled; all 4 beats delivered exactly once, in order.
- Orphan beat (valid=1, sop=0) on in1 in IDLE with in0 idle → beat consumed, nothing on out, stats_drop_beat=1.
- Rst asserted for 1 cycle mid-packet → out.valid drops to 0 immediately, all counters read 0, and the next sop on either input is forwarded normally.
